// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction fetch front end.
//   fetch_state_e   : FETCH / HALT controller states
//   fetch_entry_t   : {pc, instr} payload buffered for decode
//   OP_B            : opcode of the unconditional branch (instr[31:26])
//   next_pc()       : sequential successor, or the B target when FETCH_BPRED_EN is defined
//   pc_out_of_range(): true when a word at pc does not fit inside the ROM
// Optional feature macro: FETCH_BPRED_EN (predecode of unconditional B at enqueue).
package fetch_pkg;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [5:0] OP_B = 6'b000101;

  // Successor PC of an enqueued word.
  function automatic logic [63:0] next_pc(input logic [63:0] pc, input logic [31:0] instr);
`ifdef FETCH_BPRED_EN
    if (instr[31:26] == OP_B) begin
      next_pc = pc + {{36{instr[25]}}, instr[25:0], 2'b00};
    end else begin
      next_pc = pc + 64'd4;
    end
`else
    logic unused_instr;
    unused_instr = ^{instr, OP_B};
    next_pc = pc + 64'd4;
`endif
  endfunction

  // pc + 3 >= imem_bytes, written so pc near 2^64 cannot wrap.
  function automatic logic pc_out_of_range(input logic [63:0] pc, input logic [63:0] imem_bytes);
    pc_out_of_range = (pc > (imem_bytes - 64'd4));
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of fetch_entry_t with registered storage.
//   clk, reset_n : clock, synchronous active-low reset (clears storage, pointers, count)
//   push, wdata  : enqueue one entry (caller guarantees room, or a same-edge pop)
//   pop          : dequeue head entry
//   flush        : empty the queue; overrides push/pop
//   head         : current head entry
//   count        : occupancy, 0..DEPTH
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the instruction ROM address port, fetches one word per
// cycle into a small queue for decode, handles back-pressure, redirects and
// halts when the PC leaves the ROM.
//   clk, reset_n       : clock, synchronous active-low reset
//   imem_addr/_instr   : ROM byte address (= pc) and same-cycle read data
//   redirect/_pc       : flush and restart fetch at redirect_pc (word-aligned down)
//   if_valid/_ready    : decode handshake on the head entry
//   if_pc/_instr       : head entry fields
//   if_count           : queue occupancy
//   halted             : fetch stopped on an out-of-range pc
//   misalign_err       : sticky, a redirect_pc with nonzero low bits was seen
// Optional feature macro: FETCH_BPRED_EN (follows unconditional B at enqueue).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned IMEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC   = 64'd0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic [63:0]              imem_addr,
  input  logic [31:0]              imem_instr,
  input  logic                     redirect,
  input  logic [63:0]              redirect_pc,
  output logic                     if_valid,
  input  logic                     if_ready,
  output logic [63:0]              if_pc,
  output logic [31:0]              if_instr,
  output logic [$clog2(DEPTH):0]   if_count,
  output logic                     halted,
  output logic                     misalign_err
);

  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam logic [0:0]  ST_FETCH = 1'(FETCH);
  localparam logic [0:0]  ST_HALT  = 1'(HALT);

  logic [0:0]    state;
  logic [0:0]    state_n;
  logic [63:0]   pc;
  logic [63:0]   pc_n;
  logic          misalign_n;
  logic          push;
  logic          pop;
  logic          room;
  logic [63:0]   redirect_pc_al;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;

  assign redirect_pc_al = {redirect_pc[63:2], 2'b00};
  assign imem_addr      = pc;
  assign if_valid       = (if_count != '0) && !redirect;
  assign pop            = if_valid && if_ready;
  // A full queue can still accept when the head leaves on the same edge.
  assign room           = (if_count < CW'(DEPTH)) || pop;
  assign wr_entry       = '{pc: pc, instr: imem_instr};
  assign if_pc          = head.pc;
  assign if_instr       = head.instr;
  assign halted         = (state == ST_HALT);

  // Controller state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_FETCH;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      misalign_err <= misalign_n;
    end
  end

  // Next-state, next-pc and enqueue decision; redirect wins over everything.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    misalign_n = misalign_err;
    push       = 1'b0;
    if (redirect) begin
      pc_n    = redirect_pc_al;
      state_n = pc_out_of_range(redirect_pc_al, 64'(IMEM_BYTES)) ? ST_HALT : ST_FETCH;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_n = 1'b1;
      end
    end else if (state == ST_FETCH) begin
      if (pc_out_of_range(pc, 64'(IMEM_BYTES))) begin
        state_n = ST_HALT;
      end else if (room) begin
        push = 1'b1;
        pc_n = next_pc(pc, imem_instr);
      end
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect),
    .wdata   (wr_entry),
    .head    (head),
    .count   (if_count)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus against fetch_sequencer with a
// queue-based reference model checked every cycle, plus literal pins.
module tb_fetch_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IMEM  = 1024;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic [2:0]  if_count;
  logic        halted;
  logic        misalign_err;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] rom [256];

  ent_t        mq[$];
  logic [63:0] mpc;
  logic        mhalt;
  logic        mmis;

  always #5 clk = ~clk;

  fetch_sequencer #(.DEPTH(DEPTH), .IMEM_BYTES(IMEM), .RESET_PC(64'd0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .if_count     (if_count),
    .halted       (halted),
    .misalign_err (misalign_err)
  );

  assign imem_instr = (imem_addr < 64'(IMEM)) ? rom[imem_addr[9:2]] : 32'bx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_next(input logic [63:0] pc, input logic [31:0] w);
    logic [63:0] off;
    off = {{38{w[25]}}, w[25:0]};
`ifdef FETCH_BPRED_EN
    if (w[31:26] == 6'd5) return pc + off * 64'd4;
`endif
    return pc + 64'd4 + (off & 64'd0);
  endfunction

  // Reference model, advanced on every rising edge.
  always @(posedge clk) begin
    logic p, q;
    logic [31:0] w;
    cyc++;
    if (!reset_n) begin
      mq.delete();
      mpc   = 64'd0;
      mhalt = 1'b0;
      mmis  = 1'b0;
    end else if (redirect) begin
      mq.delete();
      mpc   = redirect_pc & ~64'd3;
      mhalt = (mpc + 64'd3 >= 64'(IMEM));
      if (redirect_pc[1:0] != 2'b00) mmis = 1'b1;
    end else begin
      p = (mq.size() != 0) && if_ready;
      q = 1'b0;
      if (!mhalt) begin
        if (mpc + 64'd3 >= 64'(IMEM)) mhalt = 1'b1;
        else if (mq.size() < DEPTH || p) q = 1'b1;
      end
      if (p) void'(mq.pop_front());
      if (q) begin
        w = rom[mpc / 4];
        mq.push_back('{pc: mpc, instr: w});
        mpc = model_next(mpc, w);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic mv;
    if (cyc > 0) begin
      mv = (mq.size() != 0) && !redirect;
      chk("m_if_valid", 64'(if_valid), 64'(mv));
      chk("m_if_count", 64'(if_count), 64'(mq.size()));
      chk("m_halted", 64'(halted), 64'(mhalt));
      chk("m_misalign", 64'(misalign_err), 64'(mmis));
      chk("m_imem_addr", imem_addr, mpc);
      if (mv) begin
        chk("m_if_pc", if_pc, mq[0].pc);
        chk("m_if_instr", 64'(if_instr), 64'(mq[0].instr));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [63:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    step(1);
    redirect    = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 + 32'(i);
    rom[4] = 32'h1400_0003;

    // Reset state.
    step(2);
    @(negedge clk);
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_count", 64'(if_count), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_misalign", 64'(misalign_err), 64'd0);
    chk("rst_if_pc", if_pc, 64'd0);
    chk("rst_if_instr", 64'(if_instr), 64'd0);
    step(1);

    // Streaming with if_ready held high.
    reset_n  = 1'b1;
    if_ready = 1'b1;
    step(1);
    @(negedge clk);
    chk("seq_first_valid", 64'(if_valid), 64'd1);
    chk("seq_first_pc", if_pc, 64'd0);
    chk("seq_first_instr", 64'(if_instr), 64'hA000_0000);
    chk("seq_first_count", 64'(if_count), 64'd1);
    step(1);
    @(negedge clk);
    chk("seq_pc4", if_pc, 64'd4);
    step(2);
    @(negedge clk);
    chk("seq_pc12", if_pc, 64'hC);
    chk("seq_instr12", 64'(if_instr), 64'hA000_0003);
    chk("seq_count", 64'(if_count), 64'd1);

    // Back-pressure fills the queue, then full pop+push.
    step(1);
    reset_n  = 1'b0;
    if_ready = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(10);
    @(negedge clk);
    chk("full_count", 64'(if_count), 64'd4);
    chk("full_addr", imem_addr, 64'h10);
    chk("full_head", if_pc, 64'd0);
    step(1);
    if_ready = 1'b1;
    step(1);
    @(negedge clk);
    chk("fullpp_count", 64'(if_count), 64'd4);
    chk("fullpp_head", if_pc, 64'd4);
    step(3);
    @(negedge clk);
    chk("fullpp_pc16", if_pc, 64'h10);
    chk("fullpp_instr16", 64'(if_instr), 64'h1400_0003);
    step(1);
    @(negedge clk);
`ifdef FETCH_BPRED_EN
    chk("bpred_target", if_pc, 64'h1C);
`else
    chk("seq_after_b", if_pc, 64'h14);
`endif

    // Redirect with three entries queued.
    step(1);
    reset_n  = 1'b0;
    if_ready = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(3);
    redirect    = 1'b1;
    redirect_pc = 64'h40;
    if_ready    = 1'b1;
    @(negedge clk);
    chk("redir_valid_same", 64'(if_valid), 64'd0);
    chk("redir_count_before", 64'(if_count), 64'd3);
    step(1);
    redirect = 1'b0;
    @(negedge clk);
    chk("redir_empty", 64'(if_count), 64'd0);
    chk("redir_bubble", 64'(if_valid), 64'd0);
    step(1);
    @(negedge clk);
    chk("redir_pc40", if_pc, 64'h40);
    chk("redir_instr40", 64'(if_instr), 64'hA000_0010);
    step(1);
    @(negedge clk);
    chk("redir_pc44", if_pc, 64'h44);

    // Last ROM word, then halt; a later redirect resumes.
    step(1);
    do_redirect(64'h3FC);
    step(1);
    @(negedge clk);
    chk("edge_pc", if_pc, 64'h3FC);
    chk("edge_addr", imem_addr, 64'h400);
    chk("edge_not_halted", 64'(halted), 64'd0);
    step(1);
    @(negedge clk);
    chk("halt_set", 64'(halted), 64'd1);
    chk("halt_count", 64'(if_count), 64'd0);
    step(3);
    @(negedge clk);
    chk("halt_hold", 64'(halted), 64'd1);
    chk("halt_addr", imem_addr, 64'h400);
    step(1);
    do_redirect(64'h8);
    @(negedge clk);
    chk("halt_clear", 64'(halted), 64'd0);
    chk("halt_clear_addr", imem_addr, 64'h8);

    // Misaligned redirect; sticky until reset.
    step(1);
    do_redirect(64'h42);
    @(negedge clk);
    chk("mis_set", 64'(misalign_err), 64'd1);
    chk("mis_addr", imem_addr, 64'h40);
    step(1);
    @(negedge clk);
    chk("mis_pc", if_pc, 64'h40);
    step(4);
    do_redirect(64'h800);
    @(negedge clk);
    chk("oor_redirect_halt", 64'(halted), 64'd1);
    chk("mis_sticky", 64'(misalign_err), 64'd1);
    step(1);
    reset_n = 1'b0;
    step(1);
    @(negedge clk);
    chk("mis_reset", 64'(misalign_err), 64'd0);
    chk("halt_reset", 64'(halted), 64'd0);
    step(1);
    reset_n = 1'b1;
    step(3);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
